// File: rtl/pipeline_if.sv
// Instruction fetch front end. Issues word fetches within an in-flight budget,
// tags each response with its PC, and buffers instructions for decode. Redirects flush the pipe.
module pipeline_if #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_inst,
   output logic [31:0] id_pc
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned SUM_W = CNT_W + 1;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic             r_run;
   logic [31:0]      r_pc;
   logic [CNT_W-1:0] r_in_flight;
   logic [CNT_W-1:0] r_drop_count;
   logic [CNT_W-1:0] r_buf_cnt;
   logic [PTR_W-1:0] r_tag_rd;
   logic [PTR_W-1:0] r_tag_wr;
   logic [PTR_W-1:0] r_buf_rd;
   logic [PTR_W-1:0] r_buf_wr;
   logic [31:0]      r_tag_mem  [DEPTH];
   logic [31:0]      r_buf_inst [DEPTH];
   logic [31:0]      r_buf_pc   [DEPTH];

   logic             w_accept;
   logic             w_resp;
   logic             w_dropping;
   logic             w_keep;
   logic             w_pop;
   logic             w_budget_ok;
   logic [SUM_W-1:0] w_occupancy;
   logic [31:0]      w_redirect_tgt;

   // In-flight count includes responses still owed from before a redirect.
   assign w_occupancy    = SUM_W'(r_in_flight) + SUM_W'(r_buf_cnt);
   assign w_budget_ok    = w_occupancy < SUM_W'(DEPTH);
   assign imem_req_valid = r_run && w_budget_ok && !redirect_valid;
   assign imem_req_addr  = r_pc;
   assign w_accept       = imem_req_valid && imem_req_ready;
   assign w_resp         = imem_resp_valid && (r_in_flight != '0);
   assign w_dropping     = r_drop_count != '0;
   assign w_keep         = w_resp && !w_dropping && !redirect_valid;
   assign w_pop          = id_valid && id_ready && !redirect_valid;
   assign w_redirect_tgt = redirect_pc & ~32'h0000_0003;

   assign id_valid = r_buf_cnt != '0;
   assign id_inst  = id_valid ? r_buf_inst[r_buf_rd] : NOP;
   assign id_pc    = id_valid ? r_buf_pc[r_buf_rd]   : 32'h0000_0000;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_run        <= 1'b0;
         r_pc         <= RESET_PC;
         r_in_flight  <= '0;
         r_drop_count <= '0;
         r_buf_cnt    <= '0;
         r_tag_rd     <= '0;
         r_tag_wr     <= '0;
         r_buf_rd     <= '0;
         r_buf_wr     <= '0;
      end else begin
         r_run <= 1'b1;

         if (redirect_valid) begin
            r_pc <= w_redirect_tgt;
         end else if (w_accept) begin
            r_pc <= r_pc + 32'd4;
         end

         if (w_accept && !w_resp) begin
            r_in_flight <= r_in_flight + CNT_W'(1);
         end else if (!w_accept && w_resp) begin
            r_in_flight <= r_in_flight - CNT_W'(1);
         end

         // Everything still owed at a redirect becomes stale; a response in that cycle is discarded too.
         if (redirect_valid) begin
            r_drop_count <= r_in_flight - CNT_W'(w_resp);
         end else if (w_resp && w_dropping) begin
            r_drop_count <= r_drop_count - CNT_W'(1);
         end

         if (redirect_valid) begin
            r_tag_rd <= '0;
            r_tag_wr <= '0;
         end else begin
            if (w_accept) r_tag_wr <= r_tag_wr + PTR_W'(1);
            if (w_keep)   r_tag_rd <= r_tag_rd + PTR_W'(1);
         end

         if (redirect_valid) begin
            r_buf_rd  <= '0;
            r_buf_wr  <= '0;
            r_buf_cnt <= '0;
         end else begin
            if (w_keep) r_buf_wr <= r_buf_wr + PTR_W'(1);
            if (w_pop)  r_buf_rd <= r_buf_rd + PTR_W'(1);
            if (w_keep && !w_pop) begin
               r_buf_cnt <= r_buf_cnt + CNT_W'(1);
            end else if (!w_keep && w_pop) begin
               r_buf_cnt <= r_buf_cnt - CNT_W'(1);
            end
         end
      end
   end

   // Storage arrays need no reset; occupancy is tracked by the pointers and counts above.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_tag_mem[r_tag_wr] <= r_pc;
      end
      if (w_keep) begin
         r_buf_inst[r_buf_wr] <= imem_resp_data;
         r_buf_pc[r_buf_wr]   <= r_tag_mem[r_tag_rd];
      end
   end
endmodule
